// File: rtl/wb_arbiter_if.sv
// Writeback bus between the decode-stage register-file write port, the pipeline
// result path, the multicycle result path and decode hazard logic.
interface wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 5
);
  logic                     pipe_wr_en_i;
  logic [SEL_W-1:0]         pipe_wr_sel_i;
  logic [DATA_W-1:0]        pipe_wr_data_i;
  logic                     mc_valid_i;
  logic                     mc_ready_o;
  logic [SEL_W-1:0]         mc_wr_sel_i;
  logic [DATA_W-1:0]        mc_wr_data_i;
  logic                     issue_i;
  logic [SEL_W-1:0]         issue_sel_i;
  logic [(1<<SEL_W)-1:0]    pending_o;
  logic                     stall_o;
  logic                     conflict_o;
  logic                     write_enable_o;
  logic [SEL_W-1:0]         write_reg_sel_o;
  logic [DATA_W-1:0]        write_data_o;

  modport slave (
    input  pipe_wr_en_i, pipe_wr_sel_i, pipe_wr_data_i,
    input  mc_valid_i, mc_wr_sel_i, mc_wr_data_i,
    input  issue_i, issue_sel_i,
    output mc_ready_o, pending_o, stall_o, conflict_o,
    output write_enable_o, write_reg_sel_o, write_data_o
  );

  modport master (
    output pipe_wr_en_i, pipe_wr_sel_i, pipe_wr_data_i,
    output mc_valid_i, mc_wr_sel_i, mc_wr_data_i,
    output issue_i, issue_sel_i,
    input  mc_ready_o, pending_o, stall_o, conflict_o,
    input  write_enable_o, write_reg_sel_o, write_data_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// Merges the pipeline and multicycle writeback sources onto the single register-file
// write port, tracking in-flight multicycle destinations and starvation of the buffer.
module wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int SEL_W        = 5,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  wb_arbiter_if.slave  bus
);
  localparam int NREG     = 1 << SEL_W;
  localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]    DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [STARVE_W-1:0] LIMIT_C = STARVE_W'(STARVE_LIMIT);

  logic [SEL_W-1:0]    fifo_sel_q  [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [NREG-1:0]     pending_q, pending_d;
  logic                stall_q, conflict_q;
  logic                we_q;
  logic [SEL_W-1:0]    sel_q;
  logic [DATA_W-1:0]   data_q;

  logic                mc_ready;
  logic                push, pop, nonempty;
  logic [SEL_W-1:0]    head_sel;
  logic [DATA_W-1:0]   head_data;

  // Ready looks only at the registered count so it never combinationally depends on valid.
  assign mc_ready  = rst_n_i && (count_q < DEPTH_C);
  assign nonempty  = (count_q != '0);
  assign push      = bus.mc_valid_i && mc_ready;
  assign pop       = !bus.pipe_wr_en_i && nonempty;
  assign head_sel  = fifo_sel_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Set after clear so a same-cycle issue to the register being retired stays pending.
  always_comb begin
    pending_d = pending_q;
    if (pop && head_sel != '0)
      pending_d[head_sel] = 1'b0;
    if (bus.issue_i && bus.issue_sel_i != '0)
      pending_d[bus.issue_sel_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    starve_d = starve_q;
    if (!nonempty || pop)
      starve_d = '0;
    else if (starve_q != LIMIT_C)
      starve_d = starve_q + STARVE_W'(1);
  end

  // Buffer storage carries no reset; only the pointers and count define its contents.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_sel_q[wr_ptr_q]  <= bus.mc_wr_sel_i;
      fifo_data_q[wr_ptr_q] <= bus.mc_wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      pending_q  <= '0;
      stall_q    <= 1'b0;
      conflict_q <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      data_q     <= '0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q   <= count_d;
      starve_q  <= starve_d;
      pending_q <= pending_d;
      stall_q   <= (starve_q == LIMIT_C) || (count_q == DEPTH_C);

      if (bus.pipe_wr_en_i && bus.pipe_wr_sel_i != '0 && pending_q[bus.pipe_wr_sel_i])
        conflict_q <= 1'b1;

      // Writes to register 0 are consumed but never reach the register file.
      if (bus.pipe_wr_en_i) begin
        we_q   <= (bus.pipe_wr_sel_i != '0);
        sel_q  <= bus.pipe_wr_sel_i;
        data_q <= bus.pipe_wr_data_i;
      end else if (pop) begin
        we_q   <= (head_sel != '0);
        sel_q  <= head_sel;
        data_q <= head_data;
      end else begin
        we_q   <= 1'b0;
      end
    end
  end

  assign bus.mc_ready_o      = mc_ready;
  assign bus.pending_o       = pending_q;
  assign bus.stall_o         = stall_q;
  assign bus.conflict_o      = conflict_q;
  assign bus.write_enable_o  = we_q;
  assign bus.write_reg_sel_o = sel_q;
  assign bus.write_data_o    = data_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, pipeline writes, multicycle writes,
// starvation stall, full buffer backpressure, register 0 and conflict tracking.
module tb_wb_arbiter;
  logic clk_i = 1'b0;
  logic rst_n_i;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk_i = ~clk_i;

  wb_arbiter_if #(.DATA_W(32), .SEL_W(5)) bus ();

  wb_arbiter #(
    .DATA_W(32), .SEL_W(5), .FIFO_DEPTH(2), .STARVE_LIMIT(4)
  ) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pipe_wr_en_i   = 1'b0;
    bus.pipe_wr_sel_i  = '0;
    bus.pipe_wr_data_i = '0;
    bus.mc_valid_i     = 1'b0;
    bus.mc_wr_sel_i    = '0;
    bus.mc_wr_data_i   = '0;
    bus.issue_i        = 1'b0;
    bus.issue_sel_i    = '0;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] sel,
                        input logic [31:0] data);
    chk({tag, "_we"},   64'(bus.write_enable_o),  64'(we));
    chk({tag, "_sel"},  64'(bus.write_reg_sel_o), 64'(sel));
    chk({tag, "_data"}, 64'(bus.write_data_o),    64'(data));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    rst_n_i = 1'b0;
    tick(); tick();
    chk("rst_we",       64'(bus.write_enable_o), 64'd0);
    chk("rst_ready",    64'(bus.mc_ready_o),     64'd0);
    chk("rst_pending",  64'(bus.pending_o),      64'd0);
    chk("rst_stall",    64'(bus.stall_o),        64'd0);
    chk("rst_conflict", 64'(bus.conflict_o),     64'd0);

    rst_n_i = 1'b1;
    repeat (5) tick();
    chk("idle_we",      64'(bus.write_enable_o), 64'd0);
    chk("idle_pending", 64'(bus.pending_o),      64'd0);
    chk("idle_ready",   64'(bus.mc_ready_o),     64'd1);
    chk("idle_stall",   64'(bus.stall_o),        64'd0);

    // Pipeline write, then hold of sel/data once idle
    bus.pipe_wr_en_i = 1'b1; bus.pipe_wr_sel_i = 5'd3; bus.pipe_wr_data_i = 32'hDEADBEEF;
    tick();
    chk_wr("pipe", 1'b1, 5'd3, 32'hDEADBEEF);
    idle_inputs();
    tick();
    chk_wr("pipe_idle", 1'b0, 5'd3, 32'hDEADBEEF);

    // Issue then multicycle completion of r7
    bus.issue_i = 1'b1; bus.issue_sel_i = 5'd7;
    tick();
    chk("pend7_set", 64'(bus.pending_o), 64'h80);
    idle_inputs();
    bus.mc_valid_i = 1'b1; bus.mc_wr_sel_i = 5'd7; bus.mc_wr_data_i = 32'h1234;
    tick();
    idle_inputs();
    chk("pend7_held", 64'(bus.pending_o), 64'h80);
    chk("mc_push_we", 64'(bus.write_enable_o), 64'd0);
    tick();
    chk_wr("mc7", 1'b1, 5'd7, 32'h1234);
    chk("pend7_clr", 64'(bus.pending_o), 64'd0);
    tick();
    chk("mc7_after_we", 64'(bus.write_enable_o), 64'd0);

    // Starvation: one buffered entry, pipeline busy 6 cycles
    bus.pipe_wr_en_i = 1'b1; bus.pipe_wr_sel_i = 5'd2; bus.pipe_wr_data_i = 32'd100;
    bus.mc_valid_i = 1'b1; bus.mc_wr_sel_i = 5'd9; bus.mc_wr_data_i = 32'hAA;
    tick();
    bus.mc_valid_i = 1'b0;
    chk_wr("starve_p0", 1'b1, 5'd2, 32'd100);
    for (int i = 1; i < 6; i++) begin
      bus.pipe_wr_data_i = 32'(100 + i);
      tick();
      chk($sformatf("starve_p%0d_data", i), 64'(bus.write_data_o), 64'(100 + i));
      if (i == 3) chk("stall_3_losses", 64'(bus.stall_o), 64'd0);
    end
    chk("stall_5_losses", 64'(bus.stall_o), 64'd1);
    idle_inputs();
    tick();
    chk_wr("starve_pop", 1'b1, 5'd9, 32'hAA);
    tick();
    chk("starve_drain_we", 64'(bus.write_enable_o), 64'd0);
    chk("stall_cleared",   64'(bus.stall_o),        64'd0);

    // Full buffer: two pushes with pipeline busy, a third held off
    bus.pipe_wr_en_i = 1'b1; bus.pipe_wr_sel_i = 5'd4; bus.pipe_wr_data_i = 32'h44;
    bus.mc_valid_i = 1'b1; bus.mc_wr_sel_i = 5'd10; bus.mc_wr_data_i = 32'h10;
    tick();
    bus.mc_wr_sel_i = 5'd11; bus.mc_wr_data_i = 32'h11;
    tick();
    chk("full_ready", 64'(bus.mc_ready_o), 64'd0);
    bus.mc_wr_sel_i = 5'd12; bus.mc_wr_data_i = 32'h12;
    tick();
    chk("full_stall", 64'(bus.stall_o),    64'd1);
    chk("full_held",  64'(bus.mc_ready_o), 64'd0);
    bus.pipe_wr_en_i = 1'b0;
    tick();
    chk_wr("full_pop0", 1'b1, 5'd10, 32'h10);
    chk("full_ready_again", 64'(bus.mc_ready_o), 64'd1);
    tick();
    bus.mc_valid_i = 1'b0;
    chk_wr("full_pop1", 1'b1, 5'd11, 32'h11);
    tick();
    chk_wr("full_pop2", 1'b1, 5'd12, 32'h12);
    tick();
    chk("full_done_we", 64'(bus.write_enable_o), 64'd0);
    chk("full_done_stall", 64'(bus.stall_o), 64'd0);

    // Register 0 entry and pipeline write to a pending register
    idle_inputs();
    bus.issue_i = 1'b1; bus.issue_sel_i = 5'd5;
    tick();
    idle_inputs();
    bus.mc_valid_i = 1'b1; bus.mc_wr_sel_i = 5'd0; bus.mc_wr_data_i = 32'h55;
    tick();
    idle_inputs();
    bus.pipe_wr_en_i = 1'b1; bus.pipe_wr_sel_i = 5'd5; bus.pipe_wr_data_i = 32'h77;
    tick();
    idle_inputs();
    chk_wr("conflict_wr", 1'b1, 5'd5, 32'h77);
    chk("conflict_set", 64'(bus.conflict_o), 64'd1);
    tick();
    chk("sel0_no_we",  64'(bus.write_enable_o), 64'd0);
    tick();
    chk("sel0_popped", 64'(bus.mc_ready_o),     64'd1);
    chk("conflict_sticky", 64'(bus.conflict_o), 64'd1);
    chk("pend5_kept",  64'(bus.pending_o),      64'h20);

    // Mid-operation reset discards a buffered entry and all tracking state
    bus.pipe_wr_en_i = 1'b1; bus.pipe_wr_sel_i = 5'd1; bus.pipe_wr_data_i = 32'h1;
    bus.mc_valid_i = 1'b1; bus.mc_wr_sel_i = 5'd6; bus.mc_wr_data_i = 32'h66;
    tick();
    idle_inputs();
    rst_n_i = 1'b0;
    tick();
    chk("mid_rst_conflict", 64'(bus.conflict_o), 64'd0);
    chk("mid_rst_pending",  64'(bus.pending_o),  64'd0);
    chk("mid_rst_ready",    64'(bus.mc_ready_o), 64'd0);
    rst_n_i = 1'b1;
    tick(); tick();
    chk("mid_rst_no_pop", 64'(bus.write_enable_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
